// File: rtl/z80_intc_pkg.sv
// Shared types and register map for the Z80 mode-2 interrupt controller.
package z80_intc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      ACK    = 2'd2,
      DONE   = 2'd3
   } intc_state_t;

   localparam logic [1:0] REG_MASK  = 2'd0;
   localparam logic [1:0] REG_VBASE = 2'd1;
   localparam logic [1:0] REG_PEND  = 2'd2;
   localparam logic [1:0] REG_EOI   = 2'd3;

   function automatic logic [7:0] bit_onehot(input logic [2:0] i);
      return 8'h01 << i;
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set: index of the lowest set bit, bit 0 wins.
module intc_prio_enc (
   input  logic [7:0] req,
   output logic [2:0] idx,
   output logic       valid
);

   always_comb begin
      idx   = 3'd0;
      valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) begin
            idx   = 3'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/z80_intc_im2.sv
// Eight-source vectored interrupt controller for Z80 mode 2 with nesting and EOI.
//
// state  | meaning
// IDLE   | no request on nINT; spurious acknowledge returns 8'hFF
// ASSERT | nINT low, waiting for the CPU acknowledge cycle
// ACK    | vector driven on the bus, winner index frozen
// DONE   | one-cycle gap before nINT may be asserted again
module z80_intc_im2
   import z80_intc_pkg::*;
#(
   parameter logic [7:0] PORT_BASE = 8'hF0
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic [7:0] A,
   input  logic [7:0] D_in,
   output logic [7:0] D_out,
   output logic       D_oe,
   input  logic       nM1,
   input  logic       nIORQ,
   input  logic       nRD,
   input  logic       nWR,
   output logic       nINT,
   input  logic [7:0] irq_req,
   output logic [7:0] irq_ack
);

   intc_state_t state;
   logic [7:0]  irq_s, irq_d;
   logic [7:0]  pend, mask, vbase, isr;
   logic [2:0]  idx;
   logic        wr_prev;

   logic [7:0]  rise, below, cand, pend_clr, eoi_clr, rd_data;
   logic [2:0]  win_idx, isr_idx;
   logic        win_valid, isr_valid;
   logic        io_sel, rd_hit, wr_hit, wr_stb, inta;

   intc_prio_enc u_prio_win (
      .req   (cand),
      .idx   (win_idx),
      .valid (win_valid)
   );

   intc_prio_enc u_prio_isr (
      .req   (isr),
      .idx   (isr_idx),
      .valid (isr_valid)
   );

   // Only sources strictly above the lowest in-service level may nest.
   always_comb begin
      rise     = irq_s & ~irq_d;
      below    = isr_valid ? (bit_onehot(isr_idx) - 8'd1) : 8'hFF;
      cand     = pend & ~mask & below;
      io_sel   = ~nIORQ & (A[7:2] == PORT_BASE[7:2]);
      rd_hit   = io_sel & nM1 & ~nRD;
      wr_hit   = io_sel & ~nWR;
      wr_stb   = wr_hit & ~wr_prev;
      inta     = ~nM1 & ~nIORQ;
      pend_clr = (state == ACK && nIORQ) ? bit_onehot(idx) : 8'h00;
      eoi_clr  = (wr_stb && A[1:0] == REG_EOI && isr_valid) ? bit_onehot(isr_idx) : 8'h00;
      unique case (A[1:0])
         REG_MASK:  rd_data = mask;
         REG_VBASE: rd_data = vbase;
         REG_PEND:  rd_data = pend;
         default:   rd_data = isr;
      endcase
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state   <= IDLE;
         irq_s   <= 8'h00;
         irq_d   <= 8'h00;
         pend    <= 8'h00;
         mask    <= 8'hFF;
         vbase   <= 8'h00;
         isr     <= 8'h00;
         idx     <= 3'd0;
         wr_prev <= 1'b0;
         nINT    <= 1'b1;
         D_oe    <= 1'b0;
         D_out   <= 8'h00;
         irq_ack <= 8'h00;
      end else begin
         irq_s   <= irq_req;
         irq_d   <= irq_s;
         wr_prev <= wr_hit;
         // A fresh edge on the bit being cleared survives the clear.
         pend    <= (pend & ~pend_clr) | rise;
         isr     <= (isr & ~eoi_clr) | pend_clr;
         irq_ack <= pend_clr;
         if (wr_stb) begin
            case (A[1:0])
               REG_MASK:  mask  <= D_in;
               REG_VBASE: vbase <= D_in;
               default:   ;
            endcase
         end

         D_oe  <= 1'b0;
         D_out <= 8'h00;
         unique case (state)
            IDLE: begin
               if (inta) begin
                  D_oe  <= 1'b1;
                  D_out <= 8'hFF;
               end else if (win_valid) begin
                  state <= ASSERT;
                  nINT  <= 1'b0;
               end
            end
            ASSERT: begin
               if (!win_valid) begin
                  state <= IDLE;
                  nINT  <= 1'b1;
               end else if (inta) begin
                  state <= ACK;
                  idx   <= win_idx;
                  D_oe  <= 1'b1;
                  D_out <= {vbase[7:4], win_idx, 1'b0};
               end
            end
            ACK: begin
               if (nIORQ) begin
                  state <= DONE;
                  nINT  <= 1'b1;
               end else begin
                  D_oe  <= 1'b1;
                  D_out <= D_out;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (rd_hit) begin
            D_oe  <= 1'b1;
            D_out <= rd_data;
         end
      end
   end

endmodule
